// File: rtl/fpu_pkg.sv
// Shared encodings and defaults for the FP issue stage: opcodes, funct5 codes,
// the NOP bubble and the default FPU writeback latency.
package fpu_pkg;

  localparam logic [6:0] OP_FLW = 7'b0000111;
  localparam logic [6:0] OP_FSW = 7'b0100111;
  localparam logic [6:0] OP_FP  = 7'b1010011;

  localparam logic [4:0] F5_FADD     = 5'b00000;
  localparam logic [4:0] F5_FSUB     = 5'b00001;
  localparam logic [4:0] F5_FMUL     = 5'b00010;
  localparam logic [4:0] F5_FCVT_W_S = 5'b11000;
  localparam logic [4:0] F5_FCVT_S_W = 5'b11010;

  localparam logic [31:0] FP_NOP = 32'h0000_0013;

  localparam int WB_LAT_DEF = 6;

endpackage

// File: rtl/fp_inst_decode.sv
// Combinational decode of the FP register usage of one instruction:
// which FP sources it reads, whether it writes an FP destination, and the indices.
module fp_inst_decode
  import fpu_pkg::*;
(
  input  logic [31:0] inst,
  output logic        reads_rs1,
  output logic        reads_rs2,
  output logic        writes_rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
);

  logic [6:0] opcode;
  logic [4:0] funct5;
  logic       unused_bits;

  assign opcode      = inst[6:0];
  assign funct5      = inst[31:27];
  assign rd          = inst[11:7];
  assign rs1         = inst[19:15];
  assign rs2         = inst[24:20];
  assign unused_bits = ^{inst[14:12], inst[26:25]};

  always_comb begin
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    writes_rd = 1'b0;
    unique case (opcode)
      OP_FLW: writes_rd = 1'b1;
      OP_FSW: reads_rs2 = 1'b1;
      OP_FP: begin
        unique case (funct5)
          F5_FADD, F5_FSUB, F5_FMUL: begin
            reads_rs1 = 1'b1;
            reads_rs2 = 1'b1;
            writes_rd = 1'b1;
          end
          F5_FCVT_W_S: reads_rs1 = 1'b1;
          F5_FCVT_S_W: writes_rd = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fp_issue_ctrl.sv
// FP issue slot with per-register writeback scoreboard feeding the FPU inst input.
// Build option: define FP_ISSUE_WB_BYPASS_EN when the register file forwards same-cycle writes.
module fp_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int WB_LAT = WB_LAT_DEF
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_inst,
  output logic        in_ready,
  input  logic        flush,
  output logic [31:0] out_inst,
  output logic        stall
);

  localparam int CNT_W = $clog2(WB_LAT);

  logic             slot_vld_p0;
  logic [31:0]      slot_inst_p0;
  logic [CNT_W-1:0] cnt [32];

  logic       reads_rs1, reads_rs2, writes_rd;
  logic [4:0] rs1, rs2, rd;
  logic       hazard, issue, accept;

  // A source is still busy while its pending write has not reached the register file.
  function automatic logic busy(input logic [CNT_W-1:0] c);
`ifdef FP_ISSUE_WB_BYPASS_EN
    return c > CNT_W'(1);
`else
    return c != '0;
`endif
  endfunction

  fp_inst_decode u_dec (
    .inst      (slot_inst_p0),
    .reads_rs1 (reads_rs1),
    .reads_rs2 (reads_rs2),
    .writes_rd (writes_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd)
  );

  assign hazard   = slot_vld_p0 && ((reads_rs1 && busy(cnt[rs1])) ||
                                    (reads_rs2 && busy(cnt[rs2])));
  assign issue    = slot_vld_p0 && !hazard && !flush;
  assign in_ready = !flush && (!slot_vld_p0 || issue);
  assign accept   = in_valid && in_ready;
  assign stall    = hazard;

  // Stage p0: issue slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld_p0 <= 1'b0;
    end else if (flush) begin
      slot_vld_p0 <= 1'b0;
    end else if (accept) begin
      slot_vld_p0 <= 1'b1;
    end else if (issue) begin
      slot_vld_p0 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      slot_inst_p0 <= in_inst;
    end
  end

  // Stage p1: FPU inst register, NOP bubble whenever nothing issues
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_inst <= FP_NOP;
    end else begin
      out_inst <= issue ? slot_inst_p0 : FP_NOP;
    end
  end

  // Scoreboard: reload on writer issue wins over the per-cycle decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        if (issue && writes_rd && (rd == 5'(r))) begin
          cnt[r] <= CNT_W'(WB_LAT - 1);
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Directed self-checking bench for fp_issue_ctrl at WB_LAT=6; inputs driven and
// outputs sampled on the falling clock edge.
module tb_fp_issue_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FP_ISSUE_WB_BYPASS_EN
  localparam int GAP = 5;
`else
  localparam int GAP = 6;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        flush;
  logic [31:0] out_inst;
  logic        stall;

  int n_chk = 0;
  int n_bad = 0;

  fp_issue_ctrl #(.WB_LAT(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_inst  (in_inst),
    .in_ready (in_ready),
    .flush    (flush),
    .out_inst (out_inst),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fp_r(input logic [4:0] f5, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
    return {f5, 2'b00, rs2, rs1, 3'b000, rd, 7'b1010011};
  endfunction

  function automatic logic [31:0] flw(input logic [4:0] rd);
    return {12'd0, 5'd0, 3'b010, rd, 7'b0000111};
  endfunction

  function automatic logic [31:0] fsw(input logic [4:0] rs2);
    return {7'd0, rs2, 5'd0, 3'b010, 5'd0, 7'b0100111};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Writer then dependent reader presented back-to-back; measure reader distance.
  task automatic run_dep(input string tag, input logic [31:0] wr, input logic [31:0] rdr);
    int found, nstall, nnop;
    @(negedge clk); in_valid = 1'b1; in_inst = wr;
    @(negedge clk); in_inst = rdr;
    @(negedge clk); in_valid = 1'b0; #1;
    chk({tag, "_wr_out"}, out_inst, wr);
    found = -1; nstall = 0; nnop = 0;
    for (int k = 0; k < 12 && found < 0; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      if (k > 0 && out_inst == rdr) found = k;
      else begin
        if (stall) nstall++;
        if (k > 0 && out_inst == NOP) nnop++;
      end
    end
    chk({tag, "_lat"}, found, GAP);
    chk({tag, "_stall"}, nstall, GAP - 1);
    chk({tag, "_nops"}, nnop, GAP - 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, c, m, w, iv;
    int seen;
    a  = fp_r(5'b00000, 5'd3, 5'd1, 5'd2);
    b  = fp_r(5'b00000, 5'd6, 5'd4, 5'd5);
    m  = fp_r(5'b00010, 5'd4, 5'd3, 5'd3);
    c  = fp_r(5'b00000, 5'd9, 5'd10, 5'd11);
    w  = fp_r(5'b00000, 5'd5, 5'd1, 5'd2);
    iv = 32'h0050_0093;

    rst = 1'b1; in_valid = 1'b0; in_inst = '0; flush = 1'b0;
    #12;
    chk("rst_out", out_inst, NOP);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_stall", stall, 1'b0);
    @(negedge clk); rst = 1'b0;

    // independent back-to-back stream
    @(negedge clk); in_valid = 1'b1; in_inst = a; #1;
    chk("ind_ready0", in_ready, 1'b1);
    @(negedge clk); in_inst = b; #1;
    chk("ind_ready1", in_ready, 1'b1);
    chk("ind_stall1", stall, 1'b0);
    @(negedge clk); in_valid = 1'b0; #1;
    chk("ind_out_a", out_inst, a);
    chk("ind_stall2", stall, 1'b0);
    @(negedge clk); #1;
    chk("ind_out_b", out_inst, b);
    @(negedge clk); #1;
    chk("ind_out_nop", out_inst, NOP);
    idle(8);

    run_dep("raw", a, m);
    idle(8);
    run_dep("st", flw(5'd7), fsw(5'd7));
    idle(8);
    run_dep("cvt", flw(5'd7), fp_r(5'b11000, 5'd5, 5'd7, 5'd0));
    idle(8);

    // flush while the dependent reader is stalled
    @(negedge clk); in_valid = 1'b1; in_inst = a;
    @(negedge clk); in_inst = m;
    @(negedge clk); in_valid = 1'b0; #1;
    chk("fl_stall", stall, 1'b1);
    @(negedge clk); flush = 1'b1; #1;
    chk("fl_ready", in_ready, 1'b0);
    @(negedge clk); flush = 1'b0; in_valid = 1'b1; in_inst = c; #1;
    chk("fl_out_nop0", out_inst, NOP);
    chk("fl_ready_after", in_ready, 1'b1);
    chk("fl_stall_after", stall, 1'b0);
    @(negedge clk); in_valid = 1'b0; #1;
    chk("fl_out_nop1", out_inst, NOP);
    @(negedge clk); #1;
    chk("fl_out_new", out_inst, c);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (out_inst == m) seen++;
    end
    chk("fl_dropped", seen, 0);
    idle(4);

    // reset while stalled
    @(negedge clk); in_valid = 1'b1; in_inst = a;
    @(negedge clk); in_inst = m;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); #1;
    chk("rs_stall", stall, 1'b1);
    @(negedge clk); rst = 1'b1; #1;
    chk("rs_out", out_inst, NOP);
    chk("rs_ready", in_ready, 1'b1);
    chk("rs_stall0", stall, 1'b0);
    @(negedge clk); rst = 1'b0; in_valid = 1'b1; in_inst = m;
    @(negedge clk); in_valid = 1'b0; #1;
    chk("rs_nostall", stall, 1'b0);
    @(negedge clk); #1;
    chk("rs_out_m", out_inst, m);
    idle(8);

    // integer passthrough with a live counter on a register its fields alias
    @(negedge clk); in_valid = 1'b1; in_inst = w;
    @(negedge clk); in_inst = iv;
    @(negedge clk); in_valid = 1'b0; #1;
    chk("int_out_w", out_inst, w);
    chk("int_stall", stall, 1'b0);
    @(negedge clk); #1;
    chk("int_out", out_inst, iv);

    idle(2);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_issue_ctrl.md
# fp_issue_ctrl

FP issue/interlock stage directly upstream of the FPU pipeline. Takes F-extension instructions from fetch/decode through a valid/ready handshake, holds one in an issue slot and keeps a per-register scoreboard of in-flight FP writes. Each cycle it drives the FPU's `inst` input with either the held instruction or a NOP bubble. This guarantees that no FP source register is read before the fixed-latency FPU writeback has landed.

## Interface
- `WB_LAT`, default 6: cycles from a writer appearing on `out_inst` to the earliest cycle a dependent reader may appear there. Legal range 2..15.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `in_valid  in  1`: upstream instruction valid.
- `in_inst  in  32`: upstream instruction.
- `in_ready  out  1`: combinational; slot can accept this cycle.
- `flush  in  1`: discard the held (unissued) instruction.
- `out_inst  out  32`: registered; feeds FPU `inst`.
- `stall  out  1`: combinational; slot valid and blocked by a hazard.

## Operation
- Decode, applied to the slot instruction:
  - Opcode `0000111` (FLW): writes fd.
  - Opcode `0100111` (FSW): reads fs2.
  - Opcode `1010011` with funct5 `00000`/`00001`/`00010` (FADD/FSUB/FMUL): reads fs1 and fs2, writes fd.
  - Opcode `1010011` with funct5 `11000` (FCVT.W.S): reads fs1, no FP write.
  - Opcode `1010011` with funct5 `11010` (FCVT.S.W): writes fd.
  - Anything else: no FP read or write; passes through unblocked.
- Scoreboard: 32 down-counters `cnt[r]`, each `$clog2(WB_LAT)` bits wide.
  - On issue of a writer, `cnt[rd]` loads `WB_LAT-1`.
  - Every other nonzero counter decrements by 1 per cycle. A reload of the same rd takes priority over its decrement.
  - f0 is tracked like any other register.
- Hazard: the slot is valid and some FP source r it reads has `cnt[r] != 0`.
- Issue condition: slot valid, no hazard, no flush.
  - On issue: `out_inst <= slot`, the slot is freed.
  - Otherwise: `out_inst <= NOP` (`32'h0000_0013`, which decodes as no FP write).
- `in_ready = !flush && (!slot_valid || issue)`. An instruction may be accepted in the same cycle the slot issues.
- WAW needs no check: FPU latency is uniform, so writes retire in order.
- Flush: clears the slot and forces a NOP next cycle. Counters are not cleared, because in-flight writes still complete.

## Timing
- Reset values: `out_inst = NOP`, `slot_valid = 0`, all counters 0. After reset, `in_ready = 1` and `stall = 0`.
- Latency, no hazard: accepted at edge E, then on `out_inst` from edge E+1 onward.
- Writer on `out_inst` in cycle t: a dependent reader appears no earlier than cycle t+`WB_LAT` (t+`WB_LAT`-1 with bypass). Independent instructions issue back-to-back.
- While stalled, the slot and `in_inst` hold, `in_ready = 0`, and `out_inst` carries NOPs.
- Simultaneous flush and issue-eligible slot: flush wins, and the instruction is dropped.
- Reset asserted mid-stall: everything returns to reset values immediately.

## Configuration
- `FP_ISSUE_WB_BYPASS_EN`:
  - Defined: the hazard test becomes `cnt[r] > 1`. This assumes the float register file forwards same-cycle write data to its read ports, and it saves one bubble per dependency.
  - Undefined: the hazard test is `cnt[r] != 0`.

## Structure
- `fpu_pkg` holds:
  - opcode constants `OP_FLW`, `OP_FSW`, `OP_FP`
  - funct5 constants for add/sub/mul/cvt
  - `FP_NOP`
  - default `WB_LAT`
- One sub-module, `fp_inst_decode`: combinational, emitting `reads_rs1`, `reads_rs2`, `writes_rd` and the register indices.

## Test plan
- Independent stream, WB_LAT=6: FADD f3,f1,f2 then FADD f6,f4,f5, back-to-back `in_valid`. Expect them on `out_inst` on consecutive cycles, `stall` never high.
- RAW: FADD f3,f1,f2 issued in cycle t, then FMUL f4,f3,f3. Expect FMUL at t+6 with NOPs at t+1..t+5 and `stall` high 5 cycles. With `FP_ISSUE_WB_BYPASS_EN`: FMUL at t+5, `stall` high 4 cycles.
- Store dependency: FLW f7 issued at t, then FSW of f7. Expect FSW at t+6. FCVT.W.S reading f7 behaves identically.
- Flush during stall: RAW as above, `flush` pulsed at t+2. Expect the slot cleared, `in_ready = 0` that cycle, NOPs only. A new independent instruction accepted at t+3 issues at t+4.
- Reset mid-stall: assert `rst` at t+3. Expect `out_inst = NOP`, `in_ready = 1`, `stall = 0` immediately. After release, FMUL f4,f3,f3 issues one cycle after acceptance.
- Non-FP passthrough: integer `32'h00500093`. Issues with one-cycle latency regardless of scoreboard contents.
